// File: rtl/tdc_command_sequencer.sv
// rtl/tdc_command_sequencer.sv - executes 48-bit host commands against the register bus, event FIFOs and rate counters
// Exactly one command is in flight at a time. Every output is registered.

module tdc_command_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [47:0]               cmd_packet,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [47:0]               rsp_packet,
  output logic                      reg_req,
  output logic                      reg_we,
  output logic [7:0]                reg_addr,
  output logic [31:0]               reg_wdata,
  input  logic                      reg_ack,
  input  logic [31:0]               reg_rdata,
  input  logic [NUM_CHANNELS-1:0]   evt_empty,
  input  logic [32*NUM_CHANNELS-1:0] evt_data,
  output logic [NUM_CHANNELS-1:0]   evt_pop,
  input  logic [32*NUM_CHANNELS-1:0] rate_count,
  output logic [NUM_CHANNELS-1:0]   rate_clear
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_REG_WAIT = 3'd2;
  localparam logic [2:0] S_EVT_LOAD = 3'd3;
  localparam logic [2:0] S_RSP      = 3'd4;

  localparam logic [4:0] RT_NACK         = 5'd0;
  localparam logic [4:0] RT_READ_REG     = 5'd1;
  localparam logic [4:0] RT_ACK_WRITE    = 5'd2;
  localparam logic [4:0] RT_SEND_EVENTS  = 5'd3;
  localparam logic [4:0] RT_EVENTS_COUNT = 5'd4;
  localparam logic [4:0] RT_ACK_RESET    = 5'd5;

  localparam logic [31:0] NACK_TIMEOUT     = 32'd1;
  localparam logic [31:0] NACK_NO_EVENTS   = 32'd2;
  localparam logic [31:0] NACK_UNKNOWN     = 32'd3;
  localparam logic [31:0] NACK_BAD_CHANNEL = 32'd4;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]              state;
  logic [4:0]              cmd_code;
  logic [7:0]              cmd_addr;
  logic [31:0]             cmd_data;
  logic [1:0]              evt_idx;
  logic [2:0]              evt_limit;
  logic                    evt_seq;
  logic [TW-1:0]           timer;

  logic [3:0]              chan;
  logic                    chan_ok;
  logic [31:0]             sel_evt;
  logic [31:0]             sel_rate;
  logic                    sel_empty;
  logic [NUM_CHANNELS-1:0] chan_onehot;
  logic                    unused_bits;

  assign unused_bits = ^cmd_packet[42:40];
  assign chan        = cmd_addr[3:0];
  assign chan_ok     = (cmd_addr[7:4] == 4'd0) && ({28'd0, chan} < 32'(NUM_CHANNELS));

  always_comb begin
    sel_evt     = '0;
    sel_rate    = '0;
    sel_empty   = 1'b1;
    chan_onehot = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (chan == 4'(i)) begin
        sel_evt        = evt_data[32*i +: 32];
        sel_rate       = rate_count[32*i +: 32];
        sel_empty      = evt_empty[i];
        chan_onehot[i] = 1'b1;
      end
    end
  end

  function automatic logic [47:0] pack(input logic [4:0] t, input logic [1:0] pn,
                                       input logic [3:0] ch, input logic [31:0] d);
    return {t, 3'b000, pn, ch, 2'b00, d};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_packet <= '0;
      reg_req    <= 1'b0;
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      evt_pop    <= '0;
      rate_clear <= '0;
      cmd_code   <= '0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      evt_idx    <= '0;
      evt_limit  <= '0;
      evt_seq    <= 1'b0;
      timer      <= '0;
    end else begin
      evt_pop    <= '0;
      rate_clear <= '0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cmd_code  <= cmd_packet[47:43];
            cmd_addr  <= cmd_packet[39:32];
            cmd_data  <= cmd_packet[31:0];
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          evt_seq <= 1'b0;
          state   <= S_RSP;
          case (cmd_code)
            5'd0, 5'd1: begin
              reg_req   <= 1'b1;
              reg_we    <= (cmd_code == 5'd1);
              reg_addr  <= cmd_addr;
              reg_wdata <= cmd_data;
              timer     <= '0;
              state     <= S_REG_WAIT;
            end
            5'd2: begin
              if (chan_ok) begin
                evt_idx   <= 2'd0;
                evt_limit <= {1'b0, cmd_data[1:0]} + 3'd1;
                state     <= S_EVT_LOAD;
              end else begin
                rsp_valid  <= 1'b1;
                rsp_packet <= pack(RT_NACK, 2'd0, chan, NACK_BAD_CHANNEL);
              end
            end
            5'd3: begin
              rsp_valid  <= 1'b1;
              rsp_packet <= chan_ok ? pack(RT_EVENTS_COUNT, 2'd0, chan, sel_rate)
                                    : pack(RT_NACK, 2'd0, chan, NACK_BAD_CHANNEL);
            end
            5'd4: begin
              rsp_valid <= 1'b1;
              // addr 0xFF is the broadcast clear, answered on the reserved channel 0xF
              if (cmd_addr == 8'hFF) begin
                rate_clear <= '1;
                rsp_packet <= pack(RT_ACK_RESET, 2'd0, 4'hF, 32'd0);
              end else if (chan_ok) begin
                rate_clear <= chan_onehot;
                rsp_packet <= pack(RT_ACK_RESET, 2'd0, chan, 32'd0);
              end else begin
                rsp_packet <= pack(RT_NACK, 2'd0, chan, NACK_BAD_CHANNEL);
              end
            end
            default: begin
              rsp_valid  <= 1'b1;
              rsp_packet <= pack(RT_NACK, 2'd0, 4'd0, NACK_UNKNOWN);
            end
          endcase
        end
        S_REG_WAIT: begin
          if (reg_ack) begin
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_packet <= reg_we ? pack(RT_ACK_WRITE, 2'd0, 4'd0, reg_wdata)
                                 : pack(RT_READ_REG, 2'd0, 4'd0, reg_rdata);
            state      <= S_RSP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_packet <= pack(RT_NACK, 2'd0, 4'd0, NACK_TIMEOUT);
            state      <= S_RSP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_EVT_LOAD: begin
          if (!sel_empty) begin
            evt_pop    <= chan_onehot;
            evt_seq    <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_packet <= pack(RT_SEND_EVENTS, evt_idx, chan, sel_evt);
            state      <= S_RSP;
          end else if (evt_idx == 2'd0) begin
            evt_seq    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_packet <= pack(RT_NACK, 2'd0, chan, NACK_NO_EVENTS);
            state      <= S_RSP;
          end else begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (evt_seq && (({1'b0, evt_idx} + 3'd1) < evt_limit)) begin
              evt_idx <= evt_idx + 2'd1;
              state   <= S_EVT_LOAD;
            end else begin
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tdc_command_sequencer.md
# tdc_command_sequencer

- Executes host commands arriving as 48-bit message packets, one at a time.
- Register commands go to the register bus; event and rate commands go to the per-channel event FIFOs and rate counters.
- Each executed event is returned as one 48-bit response packet.
- Sits between the link deserializer (command side) and the link serializer (response side) of the TDC manager.

## Interface
- NUM_CHANNELS, 4: number of TDC channels served (1..15; channel field is 4 bits).
- TIMEOUT, 255: maximum cycles to wait for reg_ack.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1 / cmd_ready  out  1 / cmd_packet  in  48: command stream. Fields: [47:43] command, [42:40] reserved, [39:32] addr, [31:0] data.
- rsp_valid  out  1 / rsp_ready  in  1 / rsp_packet  out  48: response stream. Fields: [47:43] data_type, [42:40] 0, [39:38] packet_number, [37:34] channel, [33:32] 0, [31:0] data.
- reg_req  out  1 / reg_we  out  1 / reg_addr  out  8 / reg_wdata  out  32: register bus request.
- reg_ack  in  1 / reg_rdata  in  32: register bus completion.
- evt_empty  in  NUM_CHANNELS: per-channel FIFO empty flag.
- evt_data  in  32*NUM_CHANNELS: first-word-fall-through head word per channel.
- evt_pop  out  NUM_CHANNELS: one-hot pop pulse.
- rate_count  in  32*NUM_CHANNELS / rate_clear  out  NUM_CHANNELS: rate counter values and one-cycle clear pulses.

## Operation
- Command codes: 0 read_register, 1 write_register, 2 read_events, 3 read_events_rate, 4 reset_events_rate.
- Response types: 0 nack, 1 read_reg, 2 ack_write_reg, 3 send_events, 4 events_count, 5 ack_reset_events_rate.
- Nack data codes: 1 = register timeout, 2 = no events, 3 = unknown command, 4 = bad channel.
- States: IDLE, EXEC, REG_WAIT, EVT_LOAD, RSP.
- IDLE: cmd_ready=1. A cmd handshake registers the packet and moves to EXEC.
- EXEC (1 cycle) dispatch:
  - Commands 0/1 -> REG_WAIT.
  - Command 2 -> EVT_LOAD with event index 0 and limit data[1:0]+1.
  - Commands 3/4 build the response -> RSP.
  - Codes 5..31 -> nack 3 -> RSP.
- Channel for commands 2/3/4 = addr[3:0].
  - Channel >= NUM_CHANNELS (or addr[7:4]≠0) -> nack 4, channel field = addr[3:0].
  - Exception: reset_events_rate with addr=0xFF pulses all rate_clear bits and responds on channel 0xF.
- REG_WAIT:
  - Holds reg_req=1 and stable reg_addr/reg_we/reg_wdata until reg_ack.
  - On ack, read_reg carries reg_rdata; ack_write_reg echoes reg_wdata.
  - No ack after TIMEOUT cycles -> drop reg_req, nack 1.
- EVT_LOAD:
  - Channel non-empty: capture evt_data, pulse evt_pop for exactly that cycle, build send_events with packet_number = index -> RSP.
  - Channel empty at index 0: nack 2.
  - Channel empty at index > 0: return to IDLE with no packet.
- read_events_rate: events_count, data = rate_count[ch], sampled in EXEC.
- reset_events_rate: rate_clear[ch] pulses in EXEC; ack_reset_events_rate, data=0.
- RSP: rsp_valid=1, rsp_packet stable until rsp_ready. On handshake:
  - Event sequence with index+1 < limit: increment index -> EVT_LOAD.
  - Otherwise -> IDLE.
- Non-event responses: packet_number=0; channel=0 for register responses.

## Timing
- Reset (async assert): state IDLE; cmd_ready, rsp_valid, reg_req, reg_we, evt_pop, rate_clear = 0; rsp_packet, reg_addr, reg_wdata = 0.
- cmd_ready rises on the first clk edge after reset_n deasserts.
- Reset mid-operation abandons the command; no response is emitted.
- Command handshake at edge N: EXEC in cycle N+1.
  - Immediate responses: rsp_valid from N+2.
  - Register commands: reg_req from N+2.
- reg_ack sampled high at edge M: reg_req low and rsp_valid high from M+1.
- reg_ack coincident with the timeout edge counts as ack.
- Event pacing: EVT_LOAD 1 cycle, then RSP ≥1 cycle; max throughput one event per 2 cycles.
- All outputs registered; one command outstanding at a time (cmd_ready=0 outside IDLE).

## Test plan
- write_register addr 0x10 data 0xDEADBEEF, reg_ack after 3 cycles -> one write strobe, response type 2, data 0xDEADBEEF.
- read_register addr 0x22, no ack -> reg_req high exactly 255 cycles, then nack data 1.
- read_events ch 2, data[1:0]=3, FIFO holds 2 words A,B -> send_events packet_number 0 (A), then 1 (B); exactly 2 evt_pop[2] pulses; return to IDLE.
- read_events on empty channel -> single nack data 2; read_events ch 9 with NUM_CHANNELS=4 -> nack 4, channel field 9.
- read_events_rate ch 1 with count 0x1234 -> events_count 0x1234. reset_events_rate addr 0xFF -> rate_clear=4'b1111 for one cycle, ack on channel 0xF.
- rsp_ready held low 10 cycles -> rsp_packet stable and cmd_ready=0 throughout. reset_n pulsed during REG_WAIT -> all outputs 0 immediately, no response.
